// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC register and next-PC generator.
// It selects PC+4 or a redirect target from a 3-bit PCSel code.
// A redirect that arrives while IF is stalled is held in a one-entry buffer.
// The buffer applies a priority rule: a HI-class entry (exception, eret,
// refetch) is never displaced by a LO-class entry (jump, branch, jr).
// Optional feature, enabled with macro PCGEN_REDIRECT_CNT_EN: adds a 32-bit
// Redirect_Cnt output that counts the redirects applied to PC.
module pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXCEPT_VEC = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  PCSel,
  input  logic        IF_Stall,
  input  logic [31:0] Jump_Target,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] JR_Target,
  input  logic [31:0] CP0_EPC,
  input  logic [31:0] MEM_PC,
  output logic [31:0] PC,
  output logic        PC_Valid,
  output logic        Redirect_Pending,
`ifdef PCGEN_REDIRECT_CNT_EN
  output logic [31:0] Redirect_Cnt,
`endif
  output logic        IF_AdEL
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {IDLE, PEND} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] pend_tgt, pend_tgt_nxt;
  logic            pend_hi, pend_hi_nxt;
  logic            pc_valid_nxt;
  logic            redirect;
  logic            cls_hi;

  // Candidate next PC for the current PCSel; 111 behaves as sequential fetch
  always_comb begin
    target = PC + XLEN'(4);
    unique case (PCSel)
      3'b001:  target = Jump_Target;
      3'b010:  target = CP0_EPC;
      3'b011:  target = EXCEPT_VEC;
      3'b100:  target = Branch_Target;
      3'b101:  target = JR_Target;
      3'b110:  target = MEM_PC;
      default: target = PC + XLEN'(4);
    endcase
  end

  assign redirect = (PCSel != 3'b000) && (PCSel != 3'b111);
  assign cls_hi   = (PCSel == 3'b010) || (PCSel == 3'b011) || (PCSel == 3'b110);

  // Next-state, next-PC and pending-buffer update
  always_comb begin
    state_nxt    = state;
    pc_nxt       = PC;
    pc_valid_nxt = 1'b0;
    pend_tgt_nxt = pend_tgt;
    pend_hi_nxt  = pend_hi;
    unique case (state)
      IDLE: begin
        if (!IF_Stall) begin
          pc_nxt       = target;
          pc_valid_nxt = 1'b1;
        end else if (redirect) begin
          pend_tgt_nxt = target;
          pend_hi_nxt  = cls_hi;
          state_nxt    = PEND;
        end
      end
      PEND: begin
        // HI always overwrites; LO only replaces another LO
        if (redirect && (cls_hi || !pend_hi)) begin
          pend_tgt_nxt = target;
          pend_hi_nxt  = cls_hi;
        end
        if (!IF_Stall) begin
          pc_nxt       = pend_tgt_nxt;
          pc_valid_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, PC and pending-buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      PC       <= RESET_PC;
      PC_Valid <= 1'b0;
      pend_tgt <= '0;
      pend_hi  <= 1'b0;
    end else begin
      state    <= state_nxt;
      PC       <= pc_nxt;
      PC_Valid <= pc_valid_nxt;
      pend_tgt <= pend_tgt_nxt;
      pend_hi  <= pend_hi_nxt;
    end
  end

  assign Redirect_Pending = (state == PEND);
  assign IF_AdEL          = (PC[1:0] != 2'b00);

`ifdef PCGEN_REDIRECT_CNT_EN
  logic apply;

  assign apply = !IF_Stall && ((state == PEND) || redirect);

  // Count redirects that actually land on PC; buffer overwrites are not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      Redirect_Cnt <= '0;
    end else if (apply) begin
      Redirect_Cnt <= Redirect_Cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen.
// Each step drives the inputs, waits for one clock edge and then checks the
// outputs 1 ns after that edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  PCSel;
  logic        IF_Stall;
  logic [31:0] Jump_Target, Branch_Target, JR_Target, CP0_EPC, MEM_PC;
  logic [31:0] PC;
  logic        PC_Valid, Redirect_Pending, IF_AdEL;
`ifdef PCGEN_REDIRECT_CNT_EN
  logic [31:0] Redirect_Cnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .PCSel            (PCSel),
    .IF_Stall         (IF_Stall),
    .Jump_Target      (Jump_Target),
    .Branch_Target    (Branch_Target),
    .JR_Target        (JR_Target),
    .CP0_EPC          (CP0_EPC),
    .MEM_PC           (MEM_PC),
    .PC               (PC),
    .PC_Valid         (PC_Valid),
    .Redirect_Pending (Redirect_Pending),
`ifdef PCGEN_REDIRECT_CNT_EN
    .Redirect_Cnt     (Redirect_Cnt),
`endif
    .IF_AdEL          (IF_AdEL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] sel, input logic stall);
    PCSel    = sel;
    IF_Stall = stall;
    @(posedge clk);
    #1;
  endtask

  // Checks PC, PC_Valid and Redirect_Pending together
  task automatic chk3(input string tag, input logic [31:0] pc_e, input logic v_e, input logic rp_e);
    chk({tag, "_pc"}, PC, pc_e);
    chk({tag, "_valid"}, 32'(PC_Valid), 32'(v_e));
    chk({tag, "_pend"}, 32'(Redirect_Pending), 32'(rp_e));
  endtask

  initial begin
    rst = 1'b1;
    PCSel = 3'b000;
    IF_Stall = 1'b0;
    Jump_Target = '0;
    Branch_Target = '0;
    JR_Target = '0;
    CP0_EPC = '0;
    MEM_PC = '0;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    chk3("reset", 32'hBFC0_0000, 1'b0, 1'b0);
    chk("reset_adel", 32'(IF_AdEL), 32'd0);
`ifdef PCGEN_REDIRECT_CNT_EN
    chk("reset_cnt", Redirect_Cnt, 32'd0);
`endif
    rst = 1'b0;

    // Sequential fetch
    step(3'b000, 1'b0); chk3("seq1", 32'hBFC0_0004, 1'b1, 1'b0);
    step(3'b000, 1'b0); chk3("seq2", 32'hBFC0_0008, 1'b1, 1'b0);
    step(3'b000, 1'b0); chk3("seq3", 32'hBFC0_000C, 1'b1, 1'b0);

    // Direct branch with no stall
    Branch_Target = 32'h8000_1000;
    step(3'b100, 1'b0); chk3("branch", 32'h8000_1000, 1'b1, 1'b0);

    // JR buffered across a stall, then applied on release
    JR_Target = 32'h8000_2000;
    step(3'b101, 1'b1); chk3("jr_stall0", 32'h8000_1000, 1'b0, 1'b1);
    step(3'b000, 1'b1); chk3("jr_stall1", 32'h8000_1000, 1'b0, 1'b1);
    step(3'b000, 1'b1); chk3("jr_stall2", 32'h8000_1000, 1'b0, 1'b1);
    step(3'b000, 1'b0); chk3("jr_release", 32'h8000_2000, 1'b1, 1'b0);

    // A pending exception is not displaced by a later branch
    step(3'b011, 1'b1); chk3("exc_pend", 32'h8000_2000, 1'b0, 1'b1);
    step(3'b100, 1'b1); chk3("exc_br", 32'h8000_2000, 1'b0, 1'b1);
    step(3'b000, 1'b0); chk3("exc_release", 32'hBFC0_0380, 1'b1, 1'b0);

    // A pending branch is overridden by an EPC redirect arriving in the release cycle
    CP0_EPC = 32'h8000_3000;
    step(3'b100, 1'b1); chk3("br_pend", 32'hBFC0_0380, 1'b0, 1'b1);
    step(3'b010, 1'b0); chk3("epc_win", 32'h8000_3000, 1'b1, 1'b0);

    // One LO redirect replaces another LO redirect
    Jump_Target = 32'h8000_5000;
    step(3'b100, 1'b1);
    step(3'b001, 1'b1);
    step(3'b000, 1'b0); chk3("lo_over_lo", 32'h8000_5000, 1'b1, 1'b0);

    // One HI redirect replaces another HI redirect
    MEM_PC = 32'h8000_4000;
    step(3'b011, 1'b1);
    step(3'b110, 1'b1);
    step(3'b000, 1'b0); chk3("hi_over_hi", 32'h8000_4000, 1'b1, 1'b0);

    // PC+4 wraps modulo 2^32
    JR_Target = 32'hFFFF_FFFC;
    step(3'b101, 1'b0); chk3("wrap_pre", 32'hFFFF_FFFC, 1'b1, 1'b0);
    step(3'b000, 1'b0); chk3("wrap", 32'h0000_0000, 1'b1, 1'b0);

    // Misaligned target raises IF_AdEL
    JR_Target = 32'h8000_2002;
    step(3'b101, 1'b0); chk3("adel", 32'h8000_2002, 1'b1, 1'b0);
    chk("adel_flag", 32'(IF_AdEL), 32'd1);

    // Code 111 behaves as PC+4; a stall with no redirect just holds PC
    step(3'b111, 1'b0); chk3("sel111", 32'h8000_2006, 1'b1, 1'b0);
    step(3'b111, 1'b1); chk3("stall_nored", 32'h8000_2006, 1'b0, 1'b0);
    chk("adel_flag2", 32'(IF_AdEL), 32'd1);

    // Reset in the middle of a pending redirect discards it
    step(3'b001, 1'b1); chk3("pre_rst_pend", 32'h8000_2006, 1'b0, 1'b1);
    rst = 1'b1;
    step(3'b000, 1'b1); chk3("rst_pend", 32'hBFC0_0000, 1'b0, 1'b0);
`ifdef PCGEN_REDIRECT_CNT_EN
    chk("rst_cnt", Redirect_Cnt, 32'd0);
`endif
    rst = 1'b0;
    step(3'b000, 1'b0); chk3("post_rst", 32'hBFC0_0004, 1'b1, 1'b0);
`ifdef PCGEN_REDIRECT_CNT_EN
    step(3'b100, 1'b0);
    step(3'b001, 1'b1);
    step(3'b100, 1'b1);
    step(3'b000, 1'b0);
    chk("cnt", Redirect_Cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- PC register and next-PC generator of the IF stage. Sits directly downstream of the PC-select logic and consumes its 3-bit `PCSel` code.
- Holds the fetch PC and computes PC+4. Muxes in the redirect targets.
- Buffers a redirect that arrives while IF is stalled, so it is never lost. Flags misaligned fetch addresses.

Parameters:
- RESET_PC, 32'hBFC0_0000, fetch address after reset.
- EXCEPT_VEC, 32'hBFC0_0380, exception entry target (`PCSel`=011).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- PCSel  in  3  next-PC code: 000 PC4, 001 ImmeJump, 010 EPC, 011 Except, 100 Branch, 101 JR, 110 MEMPC
- IF_Stall  in  1  IF cannot accept a new PC this cycle
- Jump_Target  in  32  immediate-jump target
- Branch_Target  in  32  branch target
- JR_Target  in  32  register-jump target
- CP0_EPC  in  32  EPC for eret
- MEM_PC  in  32  refetch address
- PC  out  32  current fetch PC
- PC_Valid  out  1  PC is a fresh request
- Redirect_Pending  out  1  a buffered redirect is waiting
- IF_AdEL  out  1  PC[1:0]!=0

Behaviour:
- Reset values: PC=RESET_PC, PC_Valid=0, Redirect_Pending=0, pending target=0, pending class=0.
- Every output is cleared this way whenever rst=1 at a clk edge, including mid-stall and mid-pending.
- First cycle after reset: PC_Valid=1.
- Target select (combinational):
  - 000 → PC+4, wraps modulo 2^32.
  - 001 → Jump_Target; 010 → CP0_EPC; 011 → EXCEPT_VEC.
  - 100 → Branch_Target; 101 → JR_Target; 110 → MEM_PC.
  - 111 → treated as 000.
- Redirect = `PCSel`≠000 and ≠111.
- Class of a redirect:
  - HI for 010, 011, 110 (exception, eret, refetch).
  - LO for 001, 100, 101 (control flow).
- State machine, 2 states: IDLE and PEND.
- IDLE:
  - IF_Stall=0: PC←selected target, PC_Valid←1.
  - IF_Stall=1 with a redirect: pending target←selected target, pending class←class, go to PEND. PC holds, PC_Valid←0.
  - IF_Stall=1 with no redirect: PC holds, PC_Valid←0.
- PEND (Redirect_Pending=1):
  - New HI redirect arrives (stall or not): it overwrites the pending entry.
  - New LO redirect arrives: it overwrites only if the pending class is LO. A HI entry is never displaced by LO.
  - 000 is ignored.
  - When IF_Stall=0: PC←winner, PC_Valid←1, go to IDLE. Winner = the incoming HI redirect if present, else the pending entry (after any LO overwrite above).
- Latency:
  - Redirect with no stall: 1 cycle, visible on PC at the next edge.
  - Buffered redirect: applied at the first edge with IF_Stall=0.
- PC_Valid is 1 only in the cycle after a PC update. It is 0 while held.
- IF_AdEL = (PC[1:0]!=2'b00). It is combinational from the PC register and only meaningful with PC_Valid.
- No redirect is ever dropped, and no PC+4 step is taken while a redirect is pending.

Optional Feature:
- Macro PCGEN_REDIRECT_CNT_EN.
- When defined: adds output `Redirect_Cnt` [31:0].
  - Increments by 1 on every edge where a redirect (direct or buffered) is applied to PC.
  - Wraps at 2^32 and resets to 0.
  - An overwrite inside PEND does not count.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then no stall with `PCSel`=000 for 3 cycles → PC sequence BFC0_0000, BFC0_0004, BFC0_0008, BFC0_000C. PC_Valid=1 from the cycle after reset release.
- `PCSel`=100, Branch_Target=8000_1000, IF_Stall=0 → next PC=8000_1000, PC_Valid=1.
- IF_Stall=1 with `PCSel`=101, JR_Target=8000_2000, then 000 for 2 cycles, then IF_Stall=0:
  - Redirect_Pending=1 and PC held at the old value throughout the stall.
  - PC=8000_2000 after the release edge; Redirect_Pending=0.
- PEND holding Except (011), then `PCSel`=100 while still stalled → on release PC=BFC0_0380; the branch is discarded.
- PEND holding Branch 8000_1000, then `PCSel`=010, CP0_EPC=8000_3000 in the release cycle → PC=8000_3000.
- PC=FFFF_FFFC with 000 → PC=0000_0000. JR_Target=8000_2002 → IF_AdEL=1. Assert rst while in PEND → PC=BFC0_0000, Redirect_Pending=0.
